// File: rtl/llr_compose_seq_if.sv
// Sample stream bundle for llr_compose_seq: (sign, magnitude) in, two's-complement LLR out.
// The slave modport is the composer; the master modport is whoever feeds it and drains it.
interface llr_compose_seq_if #(
  parameter int LLR_LEN = 4
);
  logic               in_valid;
  logic               out_in_ready;
  logic               in_sign;
  logic [LLR_LEN-2:0] in_mag;
  logic               out_valid;
  logic               in_out_ready;
  logic [LLR_LEN-1:0] out_llr;
  logic               out_last;

  modport master (
    output in_valid, in_sign, in_mag, in_out_ready,
    input  out_in_ready, out_valid, out_llr, out_last
  );

  modport slave (
    input  in_valid, in_sign, in_mag, in_out_ready,
    output out_in_ready, out_valid, out_llr, out_last
  );
endinterface

// File: rtl/llr_compose_seq.sv
// Rebuilds two's-complement LLRs from (sign, magnitude) samples through a 2-entry
// output FIFO, tagging the final sample of each CW_LEN-sample codeword with last.
module llr_compose_seq #(
  parameter     OUTTER_NAME = "",
  parameter     MODULE_NAME = "llr_compose_seq",
  parameter int LLR_LEN     = 4,
  parameter int CW_LEN      = 15
) (
  input  logic               clk,
  input  logic               in_ctr_Srst_n,
  llr_compose_seq_if.slave   io
);
  localparam int             CNT_W    = $clog2(CW_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW_LEN - 1);

  logic [1:0]         count_reg, count_next;
  logic               wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               push, pop;
  logic [LLR_LEN-1:0] conv_llr;
  logic               conv_last;

  // A negative decision with zero magnitude maps to -1 so the sign survives.
  always_comb begin
    conv_llr = {1'b0, io.in_mag};
    if (io.in_sign) begin
      if (io.in_mag == '0) conv_llr = '1;
      else                 conv_llr = ~{1'b0, io.in_mag} + LLR_LEN'(1);
    end
  end

  assign conv_last       = (cnt_reg == CNT_LAST);
  assign io.out_in_ready = (count_reg != 2'd2);
  assign io.out_valid    = (count_reg != 2'd0);
  assign push            = io.in_valid & io.out_in_ready;
  assign pop             = io.out_valid & io.in_out_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (push) cnt_next = conv_last ? '0 : cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!in_ctr_Srst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      count_reg <= count_next;
      cnt_reg   <= cnt_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Entries are cleared on reset so out_llr/out_last read as zero afterwards.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [LLR_LEN-1:0] llr_reg;
    logic               last_reg;

    always_ff @(posedge clk) begin
      if (!in_ctr_Srst_n) begin
        llr_reg  <= '0;
        last_reg <= 1'b0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        llr_reg  <= conv_llr;
        last_reg <= conv_last;
      end
    end
  end

  assign io.out_llr  = rd_ptr_reg ? g_entry[1].llr_reg  : g_entry[0].llr_reg;
  assign io.out_last = rd_ptr_reg ? g_entry[1].last_reg : g_entry[0].last_reg;
endmodule

// File: tb/tb_llr_compose_seq.sv
// Directed and random checks of llr_compose_seq against a queue model of the
// 2-entry buffer and an arithmetic model of the sign/magnitude conversion.
module tb_llr_compose_seq;
  localparam int LLR_LEN = 4;
  localparam int CW_LEN  = 15;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  llr_compose_seq_if #(.LLR_LEN(LLR_LEN)) io ();

  llr_compose_seq #(
    .OUTTER_NAME ("tb_llr_compose_seq"),
    .MODULE_NAME ("dut"),
    .LLR_LEN     (LLR_LEN),
    .CW_LEN      (CW_LEN)
  ) dut (
    .clk           (clk),
    .in_ctr_Srst_n (srst_n),
    .io            (io.slave)
  );

  int errors = 0;
  int checks = 0;

  // model state
  logic [3:0] q_llr[$];
  logic       q_last[$];
  logic [2:0] q_mag[$];
  logic       q_sign[$];
  int         m_count = 0;
  int         m_cnt = 0;
  int         out_idx = 0;

  // results of the most recent cycle
  logic       acc, popped, pop_last, pop_sign;
  logic [3:0] pop_llr;
  logic [2:0] pop_mag;
  int         pop_idx;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] conv(input logic s, input logic [2:0] m);
    int v;
    if (s) v = (m == 3'd0) ? -1 : -int'(m);
    else   v = int'(m);
    return v[3:0];
  endfunction

  function automatic logic [2:0] mag_of(input logic [3:0] x);
    logic [3:0] t;
    t = x[3] ? (4'd0 - x) : x;
    return t[2:0];
  endfunction

  // One clock: drive at negedge, check outputs, advance model, wait for next negedge.
  task automatic cycle(input logic v, input logic s, input logic [2:0] m, input logic rdy);
    logic p, q;
    io.in_valid = v; io.in_sign = s; io.in_mag = m; io.in_out_ready = rdy;
    #1;
    check_val("in_ready", io.out_in_ready, 32'(m_count != 2));
    check_val("out_valid", io.out_valid, 32'(m_count != 0));
    if (m_count != 0) begin
      check_val("out_llr", io.out_llr, q_llr[0]);
      check_val("out_last", io.out_last, q_last[0]);
    end
    p = v && (m_count != 2);
    q = (m_count != 0) && rdy;
    acc = p;
    popped = q;
    if (q) begin
      pop_llr = io.out_llr; pop_last = io.out_last;
      pop_mag = q_mag[0]; pop_sign = q_sign[0];
      out_idx++;
      pop_idx = out_idx;
      void'(q_llr.pop_front()); void'(q_last.pop_front());
      void'(q_mag.pop_front()); void'(q_sign.pop_front());
      $display("out #%0d llr=%b last=%b", pop_idx, pop_llr, pop_last);
    end
    if (p) begin
      q_llr.push_back(conv(s, m));
      q_last.push_back(m_cnt == CW_LEN - 1);
      q_mag.push_back(m);
      q_sign.push_back(s);
      m_cnt = (m_cnt == CW_LEN - 1) ? 0 : m_cnt + 1;
    end
    m_count = q_llr.size();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    io.in_valid = 1'b0; io.in_sign = 1'b0; io.in_mag = 3'd0; io.in_out_ready = 1'b0;
    srst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    srst_n = 1'b1;
    q_llr.delete(); q_last.delete(); q_mag.delete(); q_sign.delete();
    m_count = 0; m_cnt = 0; out_idx = 0;
    check_val("rst_valid", io.out_valid, 0);
    check_val("rst_llr", io.out_llr, 0);
    check_val("rst_last", io.out_last, 0);
    check_val("rst_ready", io.out_in_ready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && m_count != 0; i++) cycle(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  logic       t1_s[5]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0] t1_m[5]   = '{3'd5, 3'd5, 3'd7, 3'd0, 3'd0};
  logic [3:0] t1_exp[5] = '{4'b0101, 4'b1011, 4'b1001, 4'b1111, 4'b0000};

  initial begin
    int lasts;
    do_reset();

    // T1: conversion, one cycle latency
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, t1_s[i], t1_m[i], 1'b1);
      check_val("t1_valid", io.out_valid, 1);
      check_val("t1_llr", io.out_llr, t1_exp[i]);
    end
    drain();

    // T2: backpressure fills the buffer, third sample refused
    cycle(1'b1, 1'b0, 3'd1, 1'b0);
    cycle(1'b1, 1'b0, 3'd2, 1'b0);
    check_val("t2_full", io.out_in_ready, 0);
    cycle(1'b1, 1'b0, 3'd3, 1'b0);
    check_val("t2_refused", acc, 0);
    check_val("t2_hold", io.out_llr, 4'b0001);
    cycle(1'b1, 1'b0, 3'd3, 1'b1);
    check_val("t2_pop1", pop_llr, 4'b0001);
    check_val("t2_still_refused", acc, 0);
    // T4: count 1, push and pop together
    cycle(1'b1, 1'b0, 3'd3, 1'b1);
    check_val("t2_pop2", pop_llr, 4'b0010);
    check_val("t4_accept", acc, 1);
    check_val("t4_valid", io.out_valid, 1);
    check_val("t4_head", io.out_llr, 4'b0011);
    cycle(1'b0, 1'b0, 3'd0, 1'b1);
    check_val("t4_pop", pop_llr, 4'b0011);
    check_val("t4_empty", io.out_valid, 0);

    // T3: 30 back-to-back samples, last on outputs 15 and 30
    do_reset();
    lasts = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(i < 30, i[0], i[2:0], 1'b1);
      if (i < 30) check_val("t3_accept", acc, 1);
      if (popped) begin
        check_val("t3_last_pos", pop_last, 32'(pop_idx == 15 || pop_idx == 30));
        if (pop_last) lasts++;
      end
    end
    check_val("t3_last_count", lasts, 2);

    // T5: reset with 2 samples buffered mid-codeword
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 3'd4, 1'b1);
    cycle(1'b1, 1'b0, 3'd6, 1'b0);
    check_val("t5_full", io.out_in_ready, 0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(i < 15, 1'b0, 3'd1, 1'b1);
      if (popped) check_val("t5_last_pos", pop_last, 32'(pop_idx == 15));
    end

    // T6: random stimulus and ready; magnitude round trip
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (popped) begin
        check_val("t6_sign", pop_llr[3], pop_sign);
        if (pop_mag != 3'd0) check_val("t6_mag", mag_of(pop_llr), pop_mag);
        check_val("t6_not_min", 32'(pop_llr == 4'b1000), 0);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
